// File: rtl/fft_pkg.sv
// Shared types, Q2.16 twiddle tables and fixed-point helpers for the SDF FFT stage.
// Sample words are packed {real, imag}, each component DATA_W bits two's complement.
package fft_pkg;

  localparam int unsigned TwIdxW    = 6;
  localparam int unsigned TwTabFrac = 16;

  typedef enum logic [1:0] {
    CmulGeneral,
    CmulBypass,
    CmulNegJ
  } cmul_mode_e;

  // cos(2*pi*i/64) and sin(2*pi*i/64) in Q2.16
  localparam int TwCos [64] = '{
     65536,  65220,  64277,  62714,  60547,  57798,  54491,  50660,
     46341,  41576,  36410,  30893,  25080,  19024,  12785,   6424,
         0,  -6424, -12785, -19024, -25080, -30893, -36410, -41576,
    -46341, -50660, -54491, -57798, -60547, -62714, -64277, -65220,
    -65536, -65220, -64277, -62714, -60547, -57798, -54491, -50660,
    -46341, -41576, -36410, -30893, -25080, -19024, -12785,  -6424,
         0,   6424,  12785,  19024,  25080,  30893,  36410,  41576,
     46341,  50660,  54491,  57798,  60547,  62714,  64277,  65220
  };

  localparam int TwSin [64] = '{
         0,   6424,  12785,  19024,  25080,  30893,  36410,  41576,
     46341,  50660,  54491,  57798,  60547,  62714,  64277,  65220,
     65536,  65220,  64277,  62714,  60547,  57798,  54491,  50660,
     46341,  41576,  36410,  30893,  25080,  19024,  12785,   6424,
         0,  -6424, -12785, -19024, -25080, -30893, -36410, -41576,
    -46341, -50660, -54491, -57798, -60547, -62714, -64277, -65220,
    -65536, -65220, -64277, -62714, -60547, -57798, -54491, -50660,
    -46341, -41576, -36410, -30893, -25080, -19024, -12785,  -6424
  };

  // Re-quantise a Q2.16 table entry to frac fractional bits, round half up.
  function automatic int tw_round(input int v, input int unsigned frac);
    if (frac >= TwTabFrac) return v <<< (frac - TwTabFrac);
    return (v + (1 <<< (TwTabFrac - 1 - frac))) >>> (TwTabFrac - frac);
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [63:0] cplx_pack(input logic [63:0] re, input logic [63:0] im,
                                            input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ((re & mask) << w) | (im & mask);
  endfunction

  function automatic logic signed [63:0] cplx_re(input logic [63:0] x, input int unsigned w);
    logic signed [63:0] t;
    t = signed'(x << (64 - 2 * w));
    return t >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] cplx_im(input logic [63:0] x, input int unsigned w);
    logic signed [63:0] t;
    t = signed'(x << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// Complex multiply by a twiddle with round-half-up and saturation to DATA_W.
// W^0 passes through exactly; -j is a swap-and-negate with no multiplier rounding.
module fft_cmul import fft_pkg::*; #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TW_FRAC = 16
) (
  input  logic signed [DATA_W-1:0]  d_re_i,
  input  logic signed [DATA_W-1:0]  d_im_i,
  input  logic signed [TW_FRAC+1:0] w_re_i,
  input  logic signed [TW_FRAC+1:0] w_im_i,
  input  cmul_mode_e                mode_i,
  output logic signed [DATA_W-1:0]  p_re_o,
  output logic signed [DATA_W-1:0]  p_im_o
);

  localparam int unsigned ProdW = DATA_W + TW_FRAC + 3;
  localparam logic signed [ProdW-1:0] RoundC = ProdW'(64'sd1 <<< (TW_FRAC - 1));

  logic signed [ProdW-1:0] acc_re;
  logic signed [ProdW-1:0] acc_im;

  always_comb begin
    acc_re = ProdW'(d_re_i) * ProdW'(w_re_i) - ProdW'(d_im_i) * ProdW'(w_im_i) + RoundC;
    acc_im = ProdW'(d_re_i) * ProdW'(w_im_i) + ProdW'(d_im_i) * ProdW'(w_re_i) + RoundC;
  end

  always_comb begin
    p_re_o = d_re_i;
    p_im_o = d_im_i;
    unique case (mode_i)
      CmulGeneral: begin
        p_re_o = DATA_W'(sat_s(64'(acc_re >>> TW_FRAC), DATA_W));
        p_im_o = DATA_W'(sat_s(64'(acc_im >>> TW_FRAC), DATA_W));
      end
      CmulNegJ: begin
        // -(most negative) saturates instead of wrapping
        p_re_o = d_im_i;
        p_im_o = DATA_W'(sat_s(-64'(d_re_i), DATA_W));
      end
      CmulBypass: begin
        p_re_o = d_re_i;
        p_im_o = d_im_i;
      end
      default: begin
        p_re_o = d_re_i;
        p_im_o = d_im_i;
      end
    endcase
  end

endmodule

// File: rtl/fft_sdf_stage.sv
// Streaming radix-2 DIF single-path delay-feedback butterfly stage, registered output.
// Define FFT_STAGE_SCALE_EN to halve sum/difference (1/N overall) instead of saturating.
module fft_sdf_stage import fft_pkg::*; #(
  parameter int unsigned N_POINT = 16,
  parameter int unsigned STAGE   = 0,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TW_FRAC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [2*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [2*DATA_W-1:0]   out_data
);

  localparam int unsigned LogN    = $clog2(N_POINT);
  localparam int unsigned D       = N_POINT >> (STAGE + 1);
  localparam int unsigned LogD    = $clog2(D);
  localparam int unsigned TwW     = TW_FRAC + 2;
  localparam int unsigned SumW    = DATA_W + 1;
  localparam int unsigned SampleW = 2 * DATA_W;
  localparam int unsigned TwShift = TwIdxW - LogN;

  localparam logic [LogN-1:0] DMask = LogN'(D - 1);
  localparam logic [LogN-1:0] CntD  = LogN'(D);
  localparam logic [LogN-1:0] KNegJ = LogN'(N_POINT / 4);

  logic [LogN-1:0]    cnt_q, cnt_d;
  logic               primed_q, primed_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic [SampleW-1:0] out_data_q, out_data_d;
  logic [SampleW-1:0] fifo_q [D];
  logic [SampleW-1:0] fifo_d [D];

  logic               sof_acc;
  logic               resync;
  logic [LogN-1:0]    cnt_cur;
  logic               phase;
  logic [LogN-1:0]    k;
  logic [TwIdxW-1:0]  tw_idx;
  cmul_mode_e         mode;

  logic [SampleW-1:0]       head;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [SumW-1:0]   sum_w_re, sum_w_im, dif_w_re, dif_w_im;
  logic signed [DATA_W-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_W-1:0] prod_re, prod_im;
  logic signed [TwW-1:0]    w_re, w_im;
  logic [SampleW-1:0]       push;
  logic [SampleW-1:0]       out_sample;

  always_comb begin : ctrl
    sof_acc = in_valid & in_sof;
    resync  = sof_acc && (cnt_q != '0);
    cnt_cur = sof_acc ? '0 : cnt_q;
    phase   = cnt_cur[LogD];
    k       = (cnt_cur & DMask) << STAGE;
    tw_idx  = TwIdxW'(k) << TwShift;
    w_re    = TwW'(tw_round(TwCos[tw_idx], TW_FRAC));
    w_im    = TwW'(-tw_round(TwSin[tw_idx], TW_FRAC));
    if (k == '0) begin
      mode = CmulBypass;
    end else if (k == KNegJ) begin
      mode = CmulNegJ;
    end else begin
      mode = CmulGeneral;
    end
  end

  always_comb begin : butterfly
    head     = fifo_q[D-1];
    a_re     = DATA_W'(cplx_re(64'(head), DATA_W));
    a_im     = DATA_W'(cplx_im(64'(head), DATA_W));
    b_re     = DATA_W'(cplx_re(64'(in_data), DATA_W));
    b_im     = DATA_W'(cplx_im(64'(in_data), DATA_W));
    sum_w_re = SumW'(a_re) + SumW'(b_re);
    sum_w_im = SumW'(a_im) + SumW'(b_im);
    dif_w_re = SumW'(a_re) - SumW'(b_re);
    dif_w_im = SumW'(a_im) - SumW'(b_im);
`ifdef FFT_STAGE_SCALE_EN
    sum_re   = DATA_W'((sum_w_re + SumW'(1)) >>> 1);
    sum_im   = DATA_W'((sum_w_im + SumW'(1)) >>> 1);
    dif_re   = DATA_W'((dif_w_re + SumW'(1)) >>> 1);
    dif_im   = DATA_W'((dif_w_im + SumW'(1)) >>> 1);
`else
    sum_re   = DATA_W'(sat_s(64'(sum_w_re), DATA_W));
    sum_im   = DATA_W'(sat_s(64'(sum_w_im), DATA_W));
    dif_re   = DATA_W'(sat_s(64'(dif_w_re), DATA_W));
    dif_im   = DATA_W'(sat_s(64'(dif_w_im), DATA_W));
`endif
  end

  fft_cmul #(
    .DATA_W  (DATA_W),
    .TW_FRAC (TW_FRAC)
  ) u_cmul (
    .d_re_i (dif_re),
    .d_im_i (dif_im),
    .w_re_i (w_re),
    .w_im_i (w_im),
    .mode_i (mode),
    .p_re_o (prod_re),
    .p_im_o (prod_im)
  );

  // Fill phase forwards the stored difference; butterfly phase emits the sum.
  always_comb begin : route
    if (phase) begin
      out_sample = SampleW'(cplx_pack(64'(sum_re), 64'(sum_im), DATA_W));
      push       = SampleW'(cplx_pack(64'(prod_re), 64'(prod_im), DATA_W));
    end else begin
      out_sample = head;
      push       = in_data;
    end
  end

  always_comb begin : next_state
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    fifo_d      = fifo_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_data_d  = out_data_q;
    if (in_valid) begin
      cnt_d     = cnt_cur + LogN'(1);
      fifo_d[0] = push;
      for (int unsigned i = 1; i < D; i++) begin
        fifo_d[i] = fifo_q[i-1];
      end
      out_sof_d   = (cnt_cur == CntD);
      out_valid_d = (primed_q && !resync) || out_sof_d;
      primed_d    = out_valid_d;
      if (out_valid_d) begin
        out_data_d = out_sample;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_data_q  <= out_data_d;
    end
  end

  // Delay-line storage is don't-care until primed, so it carries no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage (N_POINT=16, STAGE=0, D=8) with hand-computed outputs.
module tb_fft_sdf_stage;

`ifdef FFT_STAGE_SCALE_EN
  localparam bit Scale = 1'b1;
`else
  localparam bit Scale = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_sof;
  logic [31:0] out_data;

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] cap [$];

  always #5 clk = ~clk;

  fft_sdf_stage #(
    .N_POINT (16),
    .STAGE   (0),
    .DATA_W  (16),
    .TW_FRAC (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_data  (out_data)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid) cap.push_back({out_sof, out_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cx(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  task automatic send(input logic sof, input logic [31:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
  endtask

  task automatic idle(input int n, input bit chk);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
      if (chk) begin
        @(posedge clk);
        #1;
        check_eq("stall_gap_valid", {63'd0, out_valid}, 64'd0);
      end
    end
  endtask

  // One frame plus 8 zeros to drain; expects 8 sums (sof on first) then 8 differences.
  task automatic run_frame(input string name, input logic [31:0] x [16],
                           input logic [31:0] e [16], input bit stall);
    logic [32:0] got;
    cap.delete();
    for (int i = 0; i < 16; i++) begin
      send(i == 0, x[i]);
      if (stall) idle(1, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 32'd0);
      if (stall) idle(1, 1'b1);
    end
    idle(1, 1'b0);
    #2;
    check_eq({name, "_count"}, 64'(cap.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      got = (i < cap.size()) ? cap[i] : 33'bx;
      check_eq($sformatf("%s_out%0d", name, i), {31'd0, got}, {31'd0, (i == 0), e[i]});
    end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got=running exp=finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] x [16];
    logic [31:0] e [16];
    logic [32:0] got;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_sof",   {63'd0, out_sof},   64'd0);
    check_eq("rst_data",  {32'd0, out_data},  64'd0);
    rst_n = 1'b1;

    x = '{default: '0};
    e = '{default: '0};
    x[0] = cx(256, 0);
    e[0] = Scale ? cx(128, 0) : cx(256, 0);
    e[8] = Scale ? cx(128, 0) : cx(256, 0);
    run_frame("impulse", x, e, 1'b0);

    x = '{default: cx(100, 0)};
    e = '{default: '0};
    for (int i = 0; i < 8; i++) e[i] = Scale ? cx(100, 0) : cx(200, 0);
    run_frame("const", x, e, 1'b0);

    x = '{default: '0};
    e = '{default: '0};
    x[4]  = cx(100, 50);
    e[4]  = Scale ? cx(50, 25) : cx(100, 50);
    e[12] = Scale ? cx(25, -50) : cx(50, -100);
    run_frame("negj", x, e, 1'b0);

    x = '{default: '0};
    e = '{default: '0};
    x[1] = cx(1000, 0);
    e[1] = Scale ? cx(500, 0) : cx(1000, 0);
    e[9] = Scale ? cx(462, -191) : cx(924, -383);
    run_frame("twiddle", x, e, 1'b0);

    x = '{default: '0};
    e = '{default: '0};
    x[0] = cx(32767, 0);
    x[8] = cx(32767, 0);
    e[0] = cx(32767, 0);
    run_frame("sat", x, e, 1'b0);

    x = '{default: '0};
    e = '{default: '0};
    x[1] = cx(1000, 0);
    e[1] = Scale ? cx(500, 0) : cx(1000, 0);
    e[9] = Scale ? cx(462, -191) : cx(924, -383);
    run_frame("stall", x, e, 1'b1);

    // Reset in the middle of a frame, then re-prime without in_sof.
    for (int i = 0; i < 5; i++) send(i == 0, cx(5, 5));
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    #2;
    check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("midrst_sof",   {63'd0, out_sof},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cap.delete();
    for (int j = 0; j < 8; j++) send(1'b0, cx((j + 1) * 10, 0));
    send(1'b0, cx(90, 0));
    #2;
    check_eq("reprime_quiet", 64'(cap.size()), 64'd0);
    idle(1, 1'b0);
    #2;
    check_eq("reprime_count", 64'(cap.size()), 64'd1);
    got = (cap.size() > 0) ? cap[0] : 33'bx;
    check_eq("reprime_first", {31'd0, got},
             {31'd0, 1'b1, (Scale ? cx(50, 0) : cx(100, 0))});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_sdf_stage.md
# fft_sdf_stage

Streaming radix-2 decimation-in-frequency butterfly stage in single-path delay-feedback form. It takes one complex sample per accepted cycle and produces one per accepted cycle. It is generic in FFT size, stage index and sample width, with rounding, saturation and an exact path for trivial twiddles. A full N-point FFT is a chain of log2(N_POINT) instances with STAGE = 0 … log2(N_POINT)-1, followed by bit-reverse reordering outside this block.

## Interface
- N_POINT, 16, FFT size; power of two, 4 … 64
- STAGE, 0, stage index; sets delay depth D = N_POINT >> (STAGE+1), D ≥ 1
- DATA_W, 16, signed width of each of real and imaginary
- TW_FRAC, 16, twiddle fractional bits; twiddles are signed TW_FRAC+2 bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  sample present this cycle
- in_sof  input  1  qualifies in_valid; marks the first sample of a frame
- in_data  input  2*DATA_W  packed sample, {real, imag}, real in the upper half
- out_valid  output  1  out_data valid
- out_sof  output  1  first output of a frame
- out_data  output  2*DATA_W  packed sample, {real, imag}

## Operation
- **Counter.** cnt is log2(N_POINT) bits and advances only on accepted samples (in_valid=1); it wraps from N_POINT-1 to 0. in_sof=1 forces the current sample to cnt=0.
- **Phase and twiddle index.** phase = cnt[log2 D]. The twiddle index is k = (cnt mod D) << STAGE, and W^k = cos(2πk/N) - j·sin(2πk/N).
- **Delay line.** D-entry complex FIFO. It shifts only on accepted samples. head = the entry written D accepted samples earlier.
- **Phase 0 (fill).**
  - Push in_data.
  - Output = head, which holds the previous block's twiddled difference.
- **Phase 1 (butterfly).** With a = head and b = in_data:
  - Output a+b.
  - Push (a-b)·W^k.
- **Sum and difference width.** Computed at DATA_W+1 bits, then either saturated to DATA_W or scaled (see Configuration).
- **Multiply, general k.**
  - re = d_re·W_re - d_im·W_im and im = d_re·W_im + d_im·W_re, at full precision.
  - Add 2^(TW_FRAC-1), arithmetic shift right by TW_FRAC, saturate to DATA_W.
- **Multiply, k=0.** Bypass the multiplier; the result is exact.
- **Multiply, k=N/4 (-j).** (re,im) → (im, -re). Negating -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- **Priming.**
  - After reset, out_valid stays 0 for the first D accepted samples.
  - The primed flag sets on reaching cnt=D in phase 1.
  - in_sof arriving while cnt≠0 is a resync: it clears primed.
- **out_sof.** Asserted on the output produced by the sample with cnt=D (the first sum of the frame).
- **Draining.** The last D outputs of a frame are differences. They emerge only while further samples are accepted; upstream drains by feeding zeros.

## Timing
- Output is registered with latency 1: an accepted sample at edge t produces out_valid/out_data at edge t+1.
- in_valid=0 freezes the counter, FIFO and primed flag. The next cycle has out_valid=0; out_data holds its last value.
- No backpressure: the consumer must accept every out_valid cycle.
- Reset values: out_valid=0, out_sof=0, out_data=0, cnt=0, primed=0. FIFO storage is not reset; its contents are don't-care while unprimed.
- Reset mid-frame: the first output appears only after D new accepted samples.
- in_sof while cnt==0 already: no effect on the primed flag.

## Configuration
- FFT_STAGE_SCALE_EN defined:
  - Sum and difference use (x + 1) >>> 1 (round half up, divide by 2) before the twiddle.
  - No saturation is needed on sum/diff.
  - The full transform scales by 1/N.
- Undefined: sum and difference saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], with no scaling.

## Structure
- **Package fft_pkg:**
  - 64-entry cos/sin twiddle tables, Q2.16 (18-bit signed).
  - Indexed as k·(64/N_POINT) and rounded to TW_FRAC.
  - A saturate function and the complex pack/unpack helpers.
- **Sub-module fft_cmul:** complex multiply with round and saturate, plus the k=0 and -j bypasses.

## Test plan
All scenarios use N_POINT=16, STAGE=0, D=8, FFT_STAGE_SCALE_EN undefined unless stated; each frame is followed by 8 zero samples to drain.

- **Impulse:** x0=(256,0), rest 0 → 8 sums (256,0),0×7 with out_sof on the first; then 8 diffs (256,0),0×7.
- **Constant:** all 16 samples (100,0) → sums (200,0)×8; diffs (0,0)×8.
- **-j path:** x4=(100,50), rest 0 → 5th diff output is exactly (50,-100).
- **General twiddle:** x1=(1000,0), rest 0 → 2nd diff output is (924,-383).
- **Saturation:** x0=x8=(32767,0) → first sum is (32767,0). With FFT_STAGE_SCALE_EN, the first sum is (32767,0) and the first diff is (0,0).
- **Stall and reset:** in_valid toggled 1/0 gives the identical output sequence at half rate. rst_n pulsed low mid-frame → out_valid=0 until 8 new samples are accepted, then out_sof on the next output.
